// File: rtl/iic_pkg.sv
// Shared call codes, tag bit positions and scheduler state encoding.
// No logic, so no latency.
// No backpressure: this package only holds constants and types.
package iic_pkg;

  // One-hot call codes driven to iic_savemod iCall
  localparam logic [1:0] CALL_NONE = 2'b00;
  localparam logic [1:0] CALL_WR   = 2'b10;
  localparam logic [1:0] CALL_RD   = 2'b01;

  // Bit positions inside iic_savemod oTag
  localparam int TAG_FULL  = 1;
  localparam int TAG_EMPTY = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    SETTLE  = 2'd3
  } state_e;

endpackage

// File: rtl/iic_sched_buf.sv
// Small synchronous byte FIFO that holds producer pushes until a write call drains them.
// Latency: a pushed byte is visible at pop_dat_o one cycle after the push edge.
// Backpressure: push is dropped when full_o is high; pop is dropped when empty_o is high.
module iic_sched_buf #(
  parameter int WDEPTH = 4,
  parameter int WAW    = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       push_i,
  input  logic [7:0] push_dat_i,
  input  logic       pop_i,
  output logic [7:0] pop_dat_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0]     mem_q [WDEPTH];
  logic [WAW-1:0] wptr_q;
  logic [WAW-1:0] rptr_q;
  logic [WAW:0]   cnt_q;
  logic           do_push;
  logic           do_pop;

  assign full_o    = (cnt_q == (WAW+1)'(WDEPTH));
  assign empty_o   = (cnt_q == '0);
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign pop_dat_o = mem_q[rptr_q];

  // Pointers wrap naturally because WDEPTH is 2**WAW; the count tracks occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are meaningful
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/iic_fifo_sched.sv
// Scheduler issuing one-hot write/read calls to iic_savemod, alternating priority when both are ready.
// Latency: push into idle system -> write call one edge after the buffer write; pop data valid the edge after iDone[0].
// Backpressure: oPushBusy when the push buffer is full, oPopBusy when the pending-pop count saturates.
module iic_fifo_sched #(
  parameter int WDEPTH = 4,
  parameter int WAW    = 2,
  parameter int PCW    = 3
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       iPushReq,
  input  logic [7:0] iPushData,
  output logic       oPushBusy,
  input  logic       iPopReq,
  output logic       oPopBusy,
  output logic [7:0] oPopData,
  output logic       oPopValid,
  output logic [1:0] oCall,
  input  logic [1:0] iDone,
  output logic [7:0] oData,
  input  logic [7:0] iData,
  input  logic [1:0] iTag,
  output logic       oBusy
);
  import iic_pkg::*;

  state_e         state_q;
  logic           prio_wr_q;
  logic           settle_q;
  logic [1:0]     call_q;
  logic [7:0]     odata_q;
  logic [7:0]     popdata_q;
  logic           popvld_q;
  logic           busy_q;
  logic [PCW-1:0] pend_q;
  logic [PCW-1:0] pend_d;

  logic       buf_full;
  logic       buf_empty;
  logic [7:0] buf_head;
  logic       push_acc;
  logic       pop_acc;
  logic       wr_ok;
  logic       rd_ok;
  logic       wr_go;
  logic       rd_go;

  assign push_acc = iPushReq & ~buf_full;
  assign pop_acc  = iPopReq & ~oPopBusy;

  iic_sched_buf #(.WDEPTH(WDEPTH), .WAW(WAW)) u_buf (
    .clk_i      (CLOCK),
    .rst_n_i    (RESET),
    .push_i     (push_acc),
    .push_dat_i (iPushData),
    .pop_i      (wr_go),
    .pop_dat_o  (buf_head),
    .full_o     (buf_full),
    .empty_o    (buf_empty)
  );

  // Launch arbitration in IDLE: a lone ready side wins, a tie goes to the priority flag
  always_comb begin
    wr_ok = ~buf_empty & ~iTag[TAG_FULL];
    rd_ok = (pend_q != '0) & ~iTag[TAG_EMPTY];
    wr_go = 1'b0;
    rd_go = 1'b0;
    if (state_q == IDLE) begin
      if (wr_ok && rd_ok) begin
        wr_go = prio_wr_q;
        rd_go = ~prio_wr_q;
      end else begin
        wr_go = wr_ok;
        rd_go = rd_ok;
      end
    end
  end

  // Pending pops: count accepted requests, consume one per read launch
  always_comb begin
    pend_d = pend_q;
    if (pop_acc && !rd_go)      pend_d = pend_q + 1'b1;
    else if (!pop_acc && rd_go) pend_d = pend_q - 1'b1;
  end

  // Pending-pop counter register
  always_ff @(posedge CLOCK) begin
    if (!RESET) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // Call sequencer: one outstanding call, then a two-cycle settle before the next decision
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q   <= IDLE;
      prio_wr_q <= 1'b1;
      settle_q  <= 1'b0;
      call_q    <= CALL_NONE;
      odata_q   <= 8'h00;
      popdata_q <= 8'h00;
      popvld_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      popvld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_go) begin
            odata_q <= buf_head;
            call_q  <= CALL_WR;
            busy_q  <= 1'b1;
            state_q <= WR_WAIT;
            if (rd_ok) prio_wr_q <= 1'b0;
          end else if (rd_go) begin
            call_q  <= CALL_RD;
            busy_q  <= 1'b1;
            state_q <= RD_WAIT;
            if (wr_ok) prio_wr_q <= 1'b1;
          end
        end
        WR_WAIT: begin
          if (iDone[1]) begin
            call_q   <= CALL_NONE;
            settle_q <= 1'b0;
            state_q  <= SETTLE;
          end
        end
        RD_WAIT: begin
          if (iDone[0]) begin
            popdata_q <= iData;
            popvld_q  <= 1'b1;
            call_q    <= CALL_NONE;
            settle_q  <= 1'b0;
            state_q   <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            settle_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oPushBusy = buf_full;
  assign oPopBusy  = &pend_q;
  assign oCall     = call_q;
  assign oData     = odata_q;
  assign oPopData  = popdata_q;
  assign oPopValid = popvld_q;
  assign oBusy     = busy_q;

endmodule
